// File: rtl/adder_pkg.sv
// Shared definitions for the digit-serial adder.
//   state_e   : controller states (IDLE, BUSY, DONE)
//   cnt_width : digit-counter width, clog2(n) with a floor of one bit
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // A single-digit configuration still needs a one-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Operand/result handshake bundle for the digit-serial adder.
//   in_valid / in_ready   : operand-side handshake
//   a, b, carry_in, sub   : operand set
//   out_valid / out_ready : result-side handshake
//   sum, carry_out, overflow : result
// master = operand producer / result consumer, slave = the adder.
interface digit_serial_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry_out;
    logic             overflow;

    modport master (
        output in_valid, a, b, carry_in, sub, out_ready,
        input  in_ready, out_valid, sum, carry_out, overflow
    );

    modport slave (
        input  in_valid, a, b, carry_in, sub, out_ready,
        output in_ready, out_valid, sum, carry_out, overflow
    );
endinterface

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, cin : addend bits and carry in
//   sum, cout : sum bit and carry out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// File: rtl/ripple_digit_adder.sv
// Combinational DIGIT-bit ripple-carry adder built from full_adder cells.
//   a, b  : digit operands
//   cin   : carry into bit 0
//   sum   : digit sum
//   cout  : carry out of the top bit
//   c_msb : carry into the top bit (needed for signed overflow)
module ripple_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout,
    output logic             c_msb
);
    // Each stage owns its carry nets so the chain is not a single
    // self-referencing vector.
    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        logic w_ci;
        logic w_co;

        if (i == 0) begin : g_first
            assign w_ci = cin;
        end else begin : g_next
            assign w_ci = g_bit[i-1].w_co;
        end

        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (w_ci),
            .sum  (sum[i]),
            .cout (w_co)
        );
    end

    assign cout  = g_bit[DIGIT-1].w_co;
    assign c_msb = g_bit[DIGIT-1].w_ci;
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder: adds a + (sub ? ~b : b) + carry_in over WIDTH/DIGIT
// cycles using one DIGIT-wide ripple chain and a registered carry.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of digit_serial_adder_if (operand and result
//           handshakes, sum, carry_out, signed overflow)
module digit_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    digit_serial_adder_if.slave   bus
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_e           r_state;
    state_e           w_next_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;          // b already conditioned by sub
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic             r_carry_out;
    logic             r_overflow;

    logic [DIGIT-1:0] w_digit_a;
    logic [DIGIT-1:0] w_digit_b;
    logic [DIGIT-1:0] w_digit_sum;
    logic             w_digit_cout;
    logic             w_digit_cmsb;
    logic             w_last;

    assign w_digit_a = r_a[r_count*DIGIT +: DIGIT];
    assign w_digit_b = r_b[r_count*DIGIT +: DIGIT];
    assign w_last    = (r_count == LAST);

    ripple_digit_adder #(
        .DIGIT (DIGIT)
    ) u_ripple (
        .a     (w_digit_a),
        .b     (w_digit_b),
        .cin   (r_carry),
        .sum   (w_digit_sum),
        .cout  (w_digit_cout),
        .c_msb (w_digit_cmsb)
    );

    // NOTE: next state gets a default before the case so every path assigns it and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (bus.in_valid)  w_next_state = BUSY;
            BUSY:    if (w_last)        w_next_state = DONE;
            DONE:    if (bus.out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            // NOTE: operand registers are individual flops rather than a memory, so they are reset too and never feed X into the adder.
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_count     <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_a     <= bus.a;
                        r_b     <= bus.sub ? ~bus.b : bus.b;
                        r_carry <= bus.carry_in;
                        r_count <= '0;
                    end
                end
                BUSY: begin
                    r_sum[r_count*DIGIT +: DIGIT] <= w_digit_sum;
                    r_carry                       <= w_digit_cout;
                    if (w_last) begin
                        // Top digit: its carries are the word-level carries.
                        r_carry_out <= w_digit_cout;
                        r_overflow  <= w_digit_cout ^ w_digit_cmsb;
                    end else begin
                        r_count <= r_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.out_valid = (r_state == DONE);
    assign bus.sum       = r_sum;
    assign bus.carry_out = r_carry_out;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: three adders (DIGIT = 1, 4, 16; WIDTH = 16) share
// one stimulus stream. Expected results come from plain integer arithmetic.
module tb_digit_serial_adder;
    localparam int WIDTH = 16;
    localparam int NDUT  = 3;

    logic clk;
    logic rst_n;

    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             carry_in;
    logic             sub;
    logic             out_ready;

    logic [NDUT-1:0]  o_in_ready;
    logic [NDUT-1:0]  o_out_valid;
    logic [NDUT-1:0]  o_carry_out;
    logic [NDUT-1:0]  o_overflow;
    logic [WIDTH-1:0] o_sum [NDUT];

    int checks = 0;
    int errors = 0;

    digit_serial_adder_if #(.WIDTH(WIDTH)) bus1  ();
    digit_serial_adder_if #(.WIDTH(WIDTH)) bus4  ();
    digit_serial_adder_if #(.WIDTH(WIDTH)) bus16 ();

    assign bus1.in_valid  = in_valid;  assign bus4.in_valid  = in_valid;  assign bus16.in_valid  = in_valid;
    assign bus1.a         = a;         assign bus4.a         = a;         assign bus16.a         = a;
    assign bus1.b         = b;         assign bus4.b         = b;         assign bus16.b         = b;
    assign bus1.carry_in  = carry_in;  assign bus4.carry_in  = carry_in;  assign bus16.carry_in  = carry_in;
    assign bus1.sub       = sub;       assign bus4.sub       = sub;       assign bus16.sub       = sub;
    assign bus1.out_ready = out_ready; assign bus4.out_ready = out_ready; assign bus16.out_ready = out_ready;

    assign o_in_ready[0]  = bus1.in_ready;   assign o_in_ready[1]  = bus4.in_ready;   assign o_in_ready[2]  = bus16.in_ready;
    assign o_out_valid[0] = bus1.out_valid;  assign o_out_valid[1] = bus4.out_valid;  assign o_out_valid[2] = bus16.out_valid;
    assign o_carry_out[0] = bus1.carry_out;  assign o_carry_out[1] = bus4.carry_out;  assign o_carry_out[2] = bus16.carry_out;
    assign o_overflow[0]  = bus1.overflow;   assign o_overflow[1]  = bus4.overflow;   assign o_overflow[2]  = bus16.overflow;
    assign o_sum[0]       = bus1.sum;        assign o_sum[1]       = bus4.sum;        assign o_sum[2]       = bus16.sum;

    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(1)) u_dut_d1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );
    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(4)) u_dut_d4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );
    digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(16)) u_dut_d16 (
        .clk (clk), .rst_n (rst_n), .bus (bus16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    function automatic int digit_of(input int k);
        case (k)
            0:       return 1;
            1:       return 4;
            default: return 16;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string when);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("%s_in_ready_d%0d", when, digit_of(k)),  32'(o_in_ready[k]),  32'd1);
            check($sformatf("%s_out_valid_d%0d", when, digit_of(k)), 32'(o_out_valid[k]), 32'd0);
            check($sformatf("%s_sum_d%0d", when, digit_of(k)),       32'(o_sum[k]),       32'd0);
            check($sformatf("%s_carry_out_d%0d", when, digit_of(k)), 32'(o_carry_out[k]), 32'd0);
            check($sformatf("%s_overflow_d%0d", when, digit_of(k)),  32'(o_overflow[k]),  32'd0);
        end
    endtask

    // One transaction on all three adders. After the last result appears,
    // out_ready is held low for `hold` cycles while new operands are offered.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                         input logic tc, input logic ts, input int hold);
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic             exp_ov;
        int               lat  [NDUT];
        bit               seen [NDUT];
        int               cyc;
        bit               all_seen;

        bb     = ts ? ~tb_v : tb_v;
        full   = {1'b0, ta} + {1'b0, bb} + {{WIDTH{1'b0}}, tc};
        exp_ov = (ta[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != ta[WIDTH-1]);

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("idle_in_ready_d%0d", digit_of(k)), 32'(o_in_ready[k]), 32'd1);
            lat[k]  = -1;
            seen[k] = 1'b0;
        end

        a = ta; b = tb_v; carry_in = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        carry_in = 1'($urandom);
        sub      = 1'($urandom);

        cyc = 0;
        while (cyc <= 40) begin
            all_seen = 1'b1;
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("busy_in_ready_d%0d", digit_of(k)), 32'(o_in_ready[k]), 32'd0);
                if (!seen[k] && o_out_valid[k]) begin
                    seen[k] = 1'b1;
                    lat[k]  = cyc;
                end
                if (!seen[k]) all_seen = 1'b0;
            end
            if (all_seen) break;
            @(posedge clk); #1;
            cyc++;
        end

        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("out_valid_seen_d%0d", digit_of(k)), 32'(seen[k]), 32'd1);
            check($sformatf("latency_d%0d", digit_of(k)), 32'(lat[k]), 32'(WIDTH / digit_of(k)));
            check($sformatf("sum_d%0d", digit_of(k)), 32'(o_sum[k]), 32'(full[WIDTH-1:0]));
            check($sformatf("carry_out_d%0d", digit_of(k)), 32'(o_carry_out[k]), 32'(full[WIDTH]));
            check($sformatf("overflow_d%0d", digit_of(k)), 32'(o_overflow[k]), 32'(exp_ov));
        end

        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            a        = 16'($urandom);
            b        = 16'($urandom);
            @(posedge clk); #1;
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("hold_out_valid_d%0d", digit_of(k)), 32'(o_out_valid[k]), 32'd1);
                check($sformatf("hold_in_ready_d%0d", digit_of(k)),  32'(o_in_ready[k]),  32'd0);
                check($sformatf("hold_sum_d%0d", digit_of(k)),       32'(o_sum[k]),       32'(full[WIDTH-1:0]));
                check($sformatf("hold_carry_out_d%0d", digit_of(k)), 32'(o_carry_out[k]), 32'(full[WIDTH]));
                check($sformatf("hold_overflow_d%0d", digit_of(k)),  32'(o_overflow[k]),  32'(exp_ov));
            end
        end

        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("release_out_valid_d%0d", digit_of(k)), 32'(o_out_valid[k]), 32'd0);
            check($sformatf("release_in_ready_d%0d", digit_of(k)),  32'(o_in_ready[k]),  32'd1);
        end
    endtask

    initial begin
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;

        // Reset state, observed before any clock edge.
        #2 rst_n = 1'b0;
        #1 check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors.
        do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 0);
        do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0);
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 0);

        // Backpressure: ten cycles in DONE with new operands offered.
        do_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 10);

        // Reset mid-operation: DIGIT=4 adder at count=2, DIGIT=16 adder in DONE.
        a = 16'h1234; b = 16'h1111; carry_in = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1 check_reset_values("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            for (int k = 0; k < NDUT; k++) begin
                check($sformatf("post_reset_out_valid_d%0d", digit_of(k)), 32'(o_out_valid[k]), 32'd0);
                check($sformatf("post_reset_in_ready_d%0d", digit_of(k)),  32'(o_in_ready[k]),  32'd1);
            end
        end
        do_op(16'h1234, 16'h1111, 1'b0, 1'b0, 0);

        // Random operands across all three digit widths.
        for (int r = 0; r < 25; r++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                  (r % 5 == 0) ? 2 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
